// File: rtl/reg_file_pkg.sv
// Shared widths and base types for the parameterised register file.
// Package defaults match the standard 16 x 32-bit core configuration.
package reg_file_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;
  localparam int RF_PC_IDX = 15;

  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard and per-read-port RAW hazard flags.
// pend updates on the clock edge; hazard is combinational from pend and this cycle's writes.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREAD  = 3,
  parameter int PC_IDX = RF_PC_IDX
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*ADDR_W-1:0] ra,
  input  logic [NREAD-1:0]        rv,
  input  logic [ADDR_W-1:0]       wa_a,
  input  logic                    we_a,
  input  logic [ADDR_W-1:0]       wa_b,
  input  logic                    we_b,
  input  logic                    iss_v,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic [NREAD-1:0]        hazard,
  output logic [2**ADDR_W-1:0]    pend
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [DEPTH-1:0]  r_pend;
  logic [DEPTH-1:0]  w_pend_nxt;
  logic [ADDR_W-1:0] w_ra [NREAD];

  for (genvar g = 0; g < NREAD; g++) begin : g_ra
    assign w_ra[g] = ra[g*ADDR_W +: ADDR_W];
  end

  // Set after clear so a same-cycle issue marks the new producer as pending.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int x = 0; x < DEPTH; x++) begin
      if ((we_a && wa_a == ADDR_W'(x)) || (we_b && wa_b == ADDR_W'(x)))
        w_pend_nxt[x] = 1'b0;
      if (iss_v && iss_addr == ADDR_W'(x) && x != PC_IDX)
        w_pend_nxt[x] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_nxt;
  end

  always_comb begin
    hazard = '0;
    for (int i = 0; i < NREAD; i++) begin
      hazard[i] = rv[i] && r_pend[w_ra[i]] && (w_ra[i] != PC_A)
                  && !(we_a && wa_a == w_ra[i]) && !(we_b && wa_b == w_ra[i]);
    end
  end

  assign pend = r_pend;
endmodule

// File: rtl/param_reg_file.sv
// Multi-read, dual-write register file with write bypass, PC alias and RAW scoreboard.
// Reads are zero-latency combinational; writes and pend updates land on the rising edge.
module param_reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREAD  = 3,
  parameter int PC_IDX = RF_PC_IDX
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*ADDR_W-1:0] ra,
  input  logic [NREAD-1:0]        rv,
  output logic [NREAD*DATA_W-1:0] rd,
  input  logic [ADDR_W-1:0]       wa_a,
  input  logic                    we_a,
  input  logic [DATA_W-1:0]       wd_a,
  input  logic [ADDR_W-1:0]       wa_b,
  input  logic                    we_b,
  input  logic [DATA_W-1:0]       wd_b,
  input  logic [DATA_W-1:0]       r15,
  input  logic                    iss_v,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic [NREAD-1:0]        hazard,
  output logic [2**ADDR_W-1:0]    pend
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] w_ra  [NREAD];

  for (genvar g = 0; g < NREAD; g++) begin : g_ra
    assign w_ra[g] = ra[g*ADDR_W +: ADDR_W];
  end

  // The PC slot is never written, so it reads back as zero from the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) r_mem[j] <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != PC_IDX) begin
          if (we_b && wa_b == ADDR_W'(j))      r_mem[j] <= wd_b;
          else if (we_a && wa_a == ADDR_W'(j)) r_mem[j] <= wd_a;
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (w_ra[i] == PC_A)                rd[i*DATA_W +: DATA_W] = r15;
      else if (we_b && wa_b == w_ra[i])   rd[i*DATA_W +: DATA_W] = wd_b;
      else if (we_a && wa_a == w_ra[i])   rd[i*DATA_W +: DATA_W] = wd_a;
      else                                rd[i*DATA_W +: DATA_W] = r_mem[w_ra[i]];
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD),
    .PC_IDX (PC_IDX)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra       (ra),
    .rv       (rv),
    .wa_a     (wa_a),
    .we_a     (we_a),
    .wa_b     (wa_b),
    .we_b     (we_b),
    .iss_v    (iss_v),
    .iss_addr (iss_addr),
    .hazard   (hazard),
    .pend     (pend)
  );
endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file: stimulus queues expected values, a negedge monitor compares them.
module tb_param_reg_file;
  import reg_file_pkg::*;

  localparam int NR = 3;
  localparam int K_RD = 0, K_HAZ = 1, K_PEND = 2, K_MEM = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NR*RF_ADDR_W-1:0]  ra;
  logic [NR-1:0]            rv;
  logic [NR*RF_DATA_W-1:0]  rd;
  rf_addr_t                 wa_a, wa_b, iss_addr;
  logic                     we_a, we_b, iss_v;
  rf_data_t                 wd_a, wd_b, r15;
  logic [NR-1:0]            hazard;
  logic [15:0]              pend;

  int          q_kind[$];
  int          q_idx[$];
  logic [31:0] q_val[$];
  string       q_name[$];
  int          n_cmp = 0;
  int          n_err = 0;

  param_reg_file #(.DATA_W(32), .ADDR_W(4), .NREAD(NR), .PC_IDX(15)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rv(rv), .rd(rd),
    .wa_a(wa_a), .we_a(we_a), .wd_a(wd_a),
    .wa_b(wa_b), .we_b(we_b), .wd_b(wd_b),
    .r15(r15), .iss_v(iss_v), .iss_addr(iss_addr),
    .hazard(hazard), .pend(pend)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] actual(int kind, int idx);
    case (kind)
      K_RD:    return rd[idx*32 +: 32];
      K_HAZ:   return 32'(hazard);
      K_PEND:  return 32'(pend);
      default: return dut.r_mem[idx];
    endcase
  endfunction

  task automatic expect_val(int kind, int idx, logic [31:0] val, string name);
    q_kind.push_back(kind);
    q_idx.push_back(idx);
    q_val.push_back(val);
    q_name.push_back(name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; iss_v = 1'b0; rv = '0;
  endtask

  task automatic setra(int p, int a);
    ra[p*RF_ADDR_W +: RF_ADDR_W] = rf_addr_t'(a);
  endtask

  // Monitor: drains every queued expectation against the settled outputs.
  always @(negedge clk) begin
    int          k, ix;
    logic [31:0] v, a;
    string       nm;
    while (q_kind.size() != 0) begin
      k  = q_kind.pop_front();
      ix = q_idx.pop_front();
      v  = q_val.pop_front();
      nm = q_name.pop_front();
      a  = actual(k, ix);
      n_cmp++;
      if (a !== v) begin
        n_err++;
        $display("FAIL %s: got 0x%0h, want 0x%0h", nm, a, v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ra = '0; rv = 3'b111; r15 = '0;
    we_a = 1'b1; wa_a = 4'd1; wd_a = 32'h123;
    we_b = 1'b0; wa_b = '0;   wd_b = '0;
    iss_v = 1'b1; iss_addr = 4'd1;
    setra(0, 0); setra(1, 2); setra(2, 3);
    step();
    expect_val(K_RD, 0, 32'h0, "reset_rd0");
    expect_val(K_RD, 1, 32'h0, "reset_rd1");
    expect_val(K_RD, 2, 32'h0, "reset_rd2");
    expect_val(K_HAZ, 0, 32'h0, "reset_hazard");
    expect_val(K_PEND, 0, 32'h0, "reset_pend");

    // Write and issue held across an in-reset edge must be dropped.
    step();
    rst_n = 1'b1; idle();
    setra(0, 1);
    expect_val(K_RD, 0, 32'h0, "reset_write_discarded");
    expect_val(K_PEND, 0, 32'h0, "reset_issue_discarded");

    step();
    we_a = 1'b1; wa_a = 4'd4; wd_a = 32'd15; setra(0, 4);
    expect_val(K_RD, 0, 32'd15, "bypass_a_r4");
    step();
    idle();
    expect_val(K_RD, 0, 32'd15, "array_r4");

    step();
    we_a = 1'b1; wa_a = 4'd3; wd_a = 32'hA;
    we_b = 1'b1; wa_b = 4'd3; wd_b = 32'hB; setra(1, 3);
    expect_val(K_RD, 1, 32'hB, "same_addr_bypass_b");
    step();
    idle();
    expect_val(K_RD, 1, 32'hB, "same_addr_array_b");
    expect_val(K_MEM, 3, 32'hB, "mem3_b_priority");

    step();
    we_a = 1'b1; wa_a = 4'd6; wd_a = 32'h66;
    we_b = 1'b1; wa_b = 4'd9; wd_b = 32'h99;
    setra(0, 6); setra(1, 9); setra(2, 3);
    expect_val(K_RD, 0, 32'h66, "split_bypass_a");
    expect_val(K_RD, 1, 32'h99, "split_bypass_b");
    expect_val(K_RD, 2, 32'hB, "split_array_r3");
    step();
    idle();
    expect_val(K_RD, 0, 32'h66, "array_r6");
    expect_val(K_RD, 1, 32'h99, "array_r9");

    step();
    r15 = 32'h108; setra(1, 15);
    we_a = 1'b1; wa_a = 4'd15; wd_a = 32'hFF;
    we_b = 1'b1; wa_b = 4'd15; wd_b = 32'h77;
    expect_val(K_RD, 1, 32'h108, "pc_read_ignores_bypass");
    step();
    idle(); r15 = 32'h20C;
    expect_val(K_RD, 1, 32'h20C, "pc_read_tracks_r15");
    expect_val(K_MEM, 15, 32'h0, "mem15_stays_zero");

    step();
    iss_v = 1'b1; iss_addr = 4'd5; setra(2, 5); rv = 3'b100;
    expect_val(K_HAZ, 0, 32'h0, "hazard_before_issue_edge");
    step();
    iss_v = 1'b0; setra(1, 5); rv = 3'b100;
    expect_val(K_HAZ, 0, 32'h4, "hazard_port2_r5");
    expect_val(K_PEND, 0, 32'h0020, "pend_r5_set");
    step();
    we_b = 1'b1; wa_b = 4'd5; wd_b = 32'h55;
    expect_val(K_HAZ, 0, 32'h0, "hazard_cleared_by_write_b");
    expect_val(K_RD, 2, 32'h55, "bypass_b_r5");
    expect_val(K_PEND, 0, 32'h0020, "pend_r5_before_edge");
    step();
    we_b = 1'b0;
    expect_val(K_PEND, 0, 32'h0, "pend_r5_cleared");
    expect_val(K_HAZ, 0, 32'h0, "hazard_after_clear");
    expect_val(K_RD, 2, 32'h55, "array_r5");

    step();
    idle(); iss_v = 1'b1; iss_addr = 4'd5;
    step();
    iss_v = 1'b0; rv = 3'b110;
    we_a = 1'b1; wa_a = 4'd5; wd_a = 32'h56;
    expect_val(K_HAZ, 0, 32'h0, "hazard_cleared_by_write_a");
    step();
    idle(); rv = 3'b110;
    expect_val(K_PEND, 0, 32'h0, "pend_r5_cleared_a");

    step();
    idle(); iss_v = 1'b1; iss_addr = 4'd7;
    we_a = 1'b1; wa_a = 4'd7; wd_a = 32'h70;
    step();
    idle(); setra(0, 7); rv = 3'b001;
    expect_val(K_PEND, 0, 32'h0080, "issue_beats_write_r7");
    expect_val(K_HAZ, 0, 32'h1, "hazard_port0_r7");
    expect_val(K_RD, 0, 32'h70, "array_r7");
    step();
    idle(); iss_v = 1'b1; iss_addr = 4'd15;
    step();
    idle(); setra(0, 15); rv = 3'b001;
    expect_val(K_PEND, 0, 32'h0080, "issue_pc_ignored");
    expect_val(K_HAZ, 0, 32'h0, "no_hazard_on_pc");
    step();
    idle(); we_b = 1'b1; wa_b = 4'd7; wd_b = 32'h71;
    step();
    idle();
    expect_val(K_PEND, 0, 32'h0, "pend_r7_cleared");

    for (int i = 1; i <= 13; i += 2) begin
      step();
      we_a = 1'b1; wa_a = rf_addr_t'(i);     wd_a = 32'(i * 32'h11);
      we_b = 1'b1; wa_b = rf_addr_t'(i + 1); wd_b = 32'((i + 1) * 32'h11);
    end
    step();
    idle(); iss_v = 1'b1; iss_addr = 4'd2;
    step();
    idle(); setra(0, 1); setra(1, 13); setra(2, 2); rv = 3'b100;
    expect_val(K_RD, 0, 32'h11, "fill_r1");
    expect_val(K_RD, 1, 32'hDD, "fill_r13");
    expect_val(K_RD, 2, 32'h22, "fill_r2");
    expect_val(K_HAZ, 0, 32'h4, "fill_hazard_r2");
    expect_val(K_PEND, 0, 32'h0004, "fill_pend_r2");

    // Mid-cycle reset pulse: state must clear before any clock edge.
    step();
    #3;
    rst_n = 1'b0;
    expect_val(K_RD, 0, 32'h0, "async_reset_rd0");
    expect_val(K_RD, 1, 32'h0, "async_reset_rd1");
    expect_val(K_RD, 2, 32'h0, "async_reset_rd2");
    expect_val(K_HAZ, 0, 32'h0, "async_reset_hazard");
    expect_val(K_PEND, 0, 32'h0, "async_reset_pend");
    expect_val(K_MEM, 14, 32'h0, "async_reset_mem14");
    step();
    rst_n = 1'b1; setra(1, 14);
    expect_val(K_RD, 1, 32'h0, "post_reset_r14");

    step();
    step();
    if (q_kind.size() != 0) begin
      n_err += q_kind.size();
      $display("FAIL drain: %0d expectations never compared, want 0", q_kind.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 4, register address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NREAD, default 3, number of read ports.
REQ-004 SHALL have parameter PC_IDX, default 15, index of the PC alias register.
REQ-005 SHALL have port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-007 SHALL have port ra, input, NREAD*ADDR_W bits, read addresses; port i is slice i.
REQ-008 SHALL have port rv, input, NREAD bits, read-valid per port; qualifies hazard only.
REQ-009 SHALL have port rd, output, NREAD*DATA_W bits, read data; port i is slice i.
REQ-010 SHALL have ports wa_a/we_a/wd_a, inputs, ADDR_W/1/DATA_W bits, write port A.
REQ-011 SHALL have ports wa_b/we_b/wd_b, inputs, ADDR_W/1/DATA_W bits, write port B.
REQ-012 SHALL have port r15, input, DATA_W bits, PC+8 value returned for reads of PC_IDX.
REQ-013 SHALL have ports iss_v/iss_addr, inputs, 1/ADDR_W bits, issue marks destination pending.
REQ-014 SHALL have port hazard, output, NREAD bits, per-port read-after-write hazard flag.
REQ-015 SHALL have port pend, output, DEPTH bits, current pending scoreboard vector.

Function
REQ-016 SHALL return rd[i] combinationally (zero-cycle latency) from the array for ra[i].
REQ-017 SHALL return r15 on rd[i] when ra[i]==PC_IDX, ignoring array contents and bypass.
REQ-018 SHALL bypass: ra[i]==wa_b with we_b -> wd_b; else ra[i]==wa_a with we_a -> wd_a; else array.
REQ-019 SHALL write wd_a/wd_b into the array on the rising edge when the respective enable is high.
REQ-020 SHALL, when both ports write the same address in one cycle, store wd_b (B has priority).
REQ-021 SHALL ignore writes to PC_IDX; the array entry at PC_IDX stays zero.
REQ-022 SHALL set pend[iss_addr] on the edge where iss_v is high, unless iss_addr==PC_IDX.
REQ-023 SHALL clear pend[x] on the edge where any enabled write port targets x.
REQ-024 SHALL, on simultaneous issue and write to the same address, leave pend[x] set (new producer wins).
REQ-025 SHALL assert hazard[i] = rv[i] & pend[ra[i]] & no enabled write to ra[i] this cycle; never for PC_IDX.
REQ-026 SHALL keep hazard and pend free of X after reset for any input values.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously clear every array entry and all pend bits to zero.
REQ-028 SHALL drive rd to zero for non-PC, non-bypassed addresses during reset, and hazard to zero.
REQ-029 SHALL discard any write or issue coincident with reset assertion; no state changes until the first edge after deassertion.

Structure
REQ-030 SHALL take DATA_W, ADDR_W, PC_IDX defaults and the data/address typedefs from shared package reg_file_pkg.
REQ-031 SHALL place pend and hazard logic in sub-module rf_scoreboard; the array and bypass stay in the top.

Verification
REQ-032 SHALL cover: reset, we_a=1 wa_a=4 wd_a=15, next cycle ra[0]=4 -> rd[0]=15.
REQ-033 SHALL cover: we_a wa_a=3 wd_a=0xA and we_b wa_b=3 wd_b=0xB same cycle -> same-cycle bypass 0xB, array 0xB after the edge.
REQ-034 SHALL cover: r15=0x108, ra[1]=15, we_a wa_a=15 wd_a=0xFF -> rd[1]=0x108, array[15] stays 0.
REQ-035 SHALL cover: iss_v iss_addr=5, then rv[2]=1 ra[2]=5 -> hazard[2]=1; add we_b wa_b=5 -> hazard[2]=0 and pend[5]=0 after the edge.
REQ-036 SHALL cover: iss_v iss_addr=7 with we_a wa_a=7 same cycle -> pend[7]=1 after the edge.
REQ-037 SHALL cover: rst_n pulsed low mid-cycle after writes to r1..r14 -> all rd zero and pend all zero immediately, without a clock edge.
